instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction fetch stage with prefetch buffering, sitting directly upstream of decode in the RV32 core. It owns the fetch PC and issues sequential word reads to the instruction memory, which has a fixed one-cycle read latency. It buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. A redirect input from execute flushes the buffer and restarts fetch at a new target.

## Interface
- DEPTH, 4 — FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000 — first fetch address after reset; word aligned.

- clk  in  1  — single clock; all state updates on rising edge.
- rst  in  1  — synchronous, active-high reset.
- imem_req  out  1  — read request to instruction memory this cycle.
- imem_addr  out  32  — byte address of the request; always word aligned.
- imem_rdata  in  32  — instruction word; valid exactly one cycle after the `imem_req` cycle.
- redirect  in  1  — flush and restart fetch (taken branch or jump).
- redirect_pc  in  32  — restart address; bits [1:0] are ignored (forced to 0).
- instr_valid  out  1  — FIFO head holds a valid instruction.
- instr  out  32  — head instruction; 0 when `instr_valid` = 0.
- instr_pc  out  32  — PC of head instruction; 0 when `instr_valid` = 0.
- instr_ready  in  1  — decode accepts the head this cycle.

## Operation
- State: `fetch_pc` (32), `inflight` (1 bit), `inflight_pc` (32), `kill` (1 bit), FIFO of {pc, instr} with `count` 0..DEPTH.
- Reset (rst = 1): `fetch_pc` = RESET_PC, `count` = 0, `inflight` = 0, `kill` = 0. While rst = 1: `imem_req` = 0, `imem_addr` = RESET_PC, `instr_valid` = 0, `instr`/`instr_pc` = 0.
- Request rule (combinational): `imem_req` = !rst && !redirect && (count + inflight < DEPTH). `imem_addr` = `fetch_pc`.
- On a request: `inflight` ← 1, `inflight_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc` + 4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
- Response: in the cycle after a request, if `kill` = 0, {inflight_pc, imem_rdata} is pushed. If `kill` = 1, the response is dropped.
- Pop: when instr_valid && instr_ready, the head is removed.
- Push and pop in the same cycle are both performed. The credit rule guarantees a push never meets a full FIFO.
- Redirect (priority over everything except rst):
  - `count` ← 0.
  - `fetch_pc` ← {redirect_pc[31:2], 2'b00}.
  - An outstanding request is marked `kill` = 1 for the next cycle.
  - `imem_req` = 0 in the redirect cycle.
- A pop coinciding with redirect counts as a completed handshake; the FIFO is still cleared.
- A redirect in the cycle a killed response arrives is legal: that response stays dropped and the new target wins.
- rst mid-operation discards all FIFO contents and any in-flight response. The response arriving in the cycle after rst is ignored.

## Timing
- Request in cycle N → rdata sampled at the end of N+1 → `instr_valid` high in N+2 (minimum latency 2).
- After rst falls in cycle 1: first `imem_req` in cycle 1 at RESET_PC. First `instr_valid` in cycle 3.
- Redirect in cycle R:
  - `instr_valid` = 0 in R+1.
  - `imem_req` at the target in R+1.
  - Target instruction valid in R+3.
- Steady state with instr_ready held at 1: one instruction per cycle, no bubbles.
- Outputs `instr_valid`, `instr`, `instr_pc` come from registered FIFO state only. There is no combinational path from `instr_ready` or `imem_rdata` to them.
- `imem_req` depends combinationally on `redirect` and `rst`.

## Structure
- Shared package `core_pkg`: XLEN = 32, INSTR_W = 32, default RESET_PC, and the {pc, instr} fetch-entry struct/width constant (64) reused by decode.
- Sub-module `sync_fifo`: parameterized width/depth, synchronous clear, with push, pop, count, and head outputs. The fetch queue instantiates it with width 64.
- Request/credit, kill, and PC logic stay in `instr_fetch_queue`.

## Test plan
- Reset then instr_ready = 1, memory returns `addr ^ 32'hA5A5_0000` → `imem_addr` sequence 0x0, 0x4, 0x8…; `instr_valid` from cycle 3; `instr_pc` 0x0, 0x4… back-to-back, each with matching data.
- instr_ready = 0 from reset → exactly 4 requests (0x0–0xC), then `imem_req` = 0 with count = 4. Raise ready → pops 0x0, 0x4, 0x8, 0xC, and requests resume at 0x10.
- Redirect to 0x0000_0100 in the cycle after a request to 0x8 → the 0x8 response is dropped; `instr_valid` = 0 next cycle; `imem_req` at 0x100 next cycle; first popped `instr_pc` = 0x100.
- redirect_pc = 0x0000_0103 → first fetch address 0x100.
- Redirect to 0xFFFF_FFF8 → `instr_pc` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Full queue plus in-flight, then rst for 1 cycle → next cycle `instr_valid` = 0, `imem_addr` = RESET_PC, stale response not pushed, fetch resumes from RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared core widths, reset PC and the fetch-entry record consumed by decode
package core_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: instruction memory port, redirect input and decode handshake
interface instr_fetch_queue_if;
  import core_pkg::*;
  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [XLEN-1:0]    instr_pc;
  logic               instr_ready;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with synchronous clear and simultaneous push/pop
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (int'(count) < DEPTH || do_pop);
  assign head = mem[rd];
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr] <= din;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential prefetch into a small FIFO with redirect flush
module instr_fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic clk,
  input logic rst,
  instr_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc, inflight_pc;
  logic inflight, kill, push, pop;
  logic [CW-1:0] count;
  fetch_entry_t head, din;
  // credit: every issued request already owns a FIFO slot, so a push never sees a full queue
  assign bus.imem_req = !rst && !bus.redirect && (int'(count) + int'(inflight) < DEPTH);
  assign bus.imem_addr = rst ? RESET_PC : fetch_pc;
  assign push = inflight && !kill;
  assign din = '{pc: inflight_pc, instr: bus.imem_rdata};
  assign bus.instr_valid = !rst && count != '0;
  assign pop = bus.instr_valid && bus.instr_ready;
  assign bus.instr = bus.instr_valid ? head.instr : '0;
  assign bus.instr_pc = bus.instr_valid ? head.pc : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      kill <= 1'b0;
    end else begin
      inflight <= bus.imem_req;
      kill <= bus.redirect && inflight;
      if (bus.redirect) fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (bus.imem_req) fetch_pc <= fetch_pc + XLEN'(4);
    end
  end
  always_ff @(posedge clk) if (bus.imem_req) inflight_pc <= fetch_pc;
  sync_fifo #(.WIDTH(FETCH_ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(bus.redirect),
    .push(push),
    .din(din),
    .pop(pop),
    .count(count),
    .head(head)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed table, corner sequences and random run against a scoreboard
module tb_instr_fetch_queue;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  instr_fetch_queue_if bus();
  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? (bus.imem_addr ^ KEY) : 32'hBAD0_0BAD;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    bus.instr_ready = rdy;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    step();
    step();
    #1;
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", bus.instr, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int nreq, npop, first_req, pops;
    int occ;
    logic [31:0] req_pc, pop_pc, tgt;
    tbl[0]  = '{0, 0,            1, 32'h0,        0, 0};
    tbl[1]  = '{0, 0,            1, 32'h4,        0, 0};
    tbl[2]  = '{0, 0,            1, 32'h8,        1, 32'h0};
    tbl[3]  = '{1, 32'h100,      0, 0,            1, 32'h4};
    tbl[4]  = '{0, 0,            1, 32'h100,      0, 0};
    tbl[5]  = '{0, 0,            1, 32'h104,      0, 0};
    tbl[6]  = '{0, 0,            1, 32'h108,      1, 32'h100};
    tbl[7]  = '{1, 32'h103,      0, 0,            1, 32'h104};
    tbl[8]  = '{0, 0,            1, 32'h100,      0, 0};
    tbl[9]  = '{0, 0,            1, 32'h104,      0, 0};
    tbl[10] = '{0, 0,            1, 32'h108,      1, 32'h100};
    tbl[11] = '{1, 32'hFFFF_FFF8, 0, 0,           1, 32'h104};
    tbl[12] = '{0, 0,            1, 32'hFFFF_FFF8, 0, 0};
    tbl[13] = '{0, 0,            1, 32'hFFFF_FFFC, 0, 0};
    tbl[14] = '{0, 0,            1, 32'h0,        1, 32'hFFFF_FFF8};
    tbl[15] = '{0, 0,            1, 32'h4,        1, 32'hFFFF_FFFC};
    tbl[16] = '{0, 0,            1, 32'h8,        1, 32'h0};

    do_reset(1'b1);
    for (int i = 0; i < 17; i++) begin
      bus.redirect = tbl[i].rd;
      bus.redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("tbl%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_pc", i), bus.instr_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), bus.instr, tbl[i].v ? (tbl[i].pc ^ KEY) : 32'h0);
      step();
    end
    bus.redirect = 1'b0;

    do_reset(1'b0);
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.imem_req) begin
        chk("fill_addr", bus.imem_addr, 32'(nreq * 4));
        nreq++;
      end
      step();
    end
    chk("fill_reqs", 32'(nreq), 4);
    #1;
    chk("full_no_req", 32'(bus.imem_req), 0);
    bus.instr_ready = 1'b1;
    npop = 0;
    first_req = -1;
    for (int i = 0; i < 8 && npop < 4; i++) begin
      #1;
      if (bus.imem_req && first_req < 0) first_req = int'(bus.imem_addr);
      if (bus.instr_valid) begin
        chk("drain_pc", bus.instr_pc, 32'(npop * 4));
        npop++;
      end
      step();
    end
    chk("drain_pops", 32'(npop), 4);
    chk("resume_addr", 32'(first_req), 32'h10);

    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(bus.imem_req), 0);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    chk("midrst_valid", 32'(bus.instr_valid), 0);
    step();
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    #1;
    chk("post_rst_valid1", 32'(bus.instr_valid), 0);
    chk("post_rst_req", 32'(bus.imem_req), 1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    step();
    chk("post_rst_valid2", 32'(bus.instr_valid), 0);
    step();
    chk("post_rst_valid3", 32'(bus.instr_valid), 1);
    chk("post_rst_pc", bus.instr_pc, 32'h0);

    do_reset(1'b1);
    occ = 0;
    req_pc = 32'h0;
    pop_pc = 32'h0;
    pops = 0;
    for (int i = 0; i < 2000; i++) begin
      bus.instr_ready = $urandom_range(0, 3) != 0;
      bus.redirect = $urandom_range(0, 19) == 0;
      tgt = $urandom_range(0, 1) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      bus.redirect_pc = tgt;
      #1;
      chk("rnd_req", 32'(bus.imem_req), 32'(!bus.redirect && occ < DEPTH));
      if (bus.imem_req) chk("rnd_addr", bus.imem_addr, req_pc);
      if (occ == 0) chk("rnd_empty", 32'(bus.instr_valid), 0);
      if (!bus.instr_valid) chk("rnd_idle_out", bus.instr | bus.instr_pc, 0);
      if (bus.instr_valid && bus.instr_ready) begin
        chk("rnd_pop_pc", bus.instr_pc, pop_pc);
        chk("rnd_pop_instr", bus.instr, pop_pc ^ KEY);
        pops++;
      end
      if (bus.redirect) begin
        occ = 0;
        req_pc = {tgt[31:2], 2'b00};
        pop_pc = req_pc;
      end else begin
        if (occ < DEPTH) begin
          occ++;
          req_pc += 4;
        end
        if (bus.instr_valid && bus.instr_ready) begin
          occ--;
          pop_pc += 4;
        end
      end
      step();
    end
    chk("rnd_progress", 32'(pops >= 200), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
